// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: default widths and the index_cor tag layout.
package cordic_pkg;

    localparam int unsigned CORDIC_CH_W  = 16;
    localparam int unsigned CORDIC_NCH   = 2;
    localparam int unsigned CORDIC_TAG_W = 11;

    // index_cor: {spare, quadrant, iteration index}
    localparam int unsigned QUA_LSB = 7;
    localparam int unsigned QUA_W   = 3;
    localparam int unsigned COR_W   = 7;

    typedef struct packed {
        logic             spare;
        logic [QUA_W-1:0] qua;
        logic [COR_W-1:0] cor;
    } index_cor_t;

    function automatic logic [QUA_W-1:0] tag_quadrant(input logic [CORDIC_TAG_W-1:0] tag);
        return tag[QUA_LSB +: QUA_W];
    endfunction

endpackage

// File: rtl/cordic_dly_stage.sv
// One side-band delay stage {valid, tag, data}; flush clears valid only.
module cordic_dly_stage
    import cordic_pkg::*;
#(
    parameter int unsigned TAG_W  = CORDIC_TAG_W,
    parameter int unsigned DATA_W = CORDIC_NCH * CORDIC_CH_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              d_v,
    input  logic [TAG_W-1:0]  d_tag,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_v,
    output logic [TAG_W-1:0]  q_tag,
    output logic [DATA_W-1:0] q_data
);

    logic              v_q, v_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        v_d    = v_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (en) begin
            v_d    = d_v;
            tag_d  = d_tag;
            data_d = d_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q    <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    assign q_v    = v_q;
    assign q_tag  = tag_q;
    assign q_data = data_q;

endmodule

// File: rtl/cordic_sideband_delay.sv
// Configurable-depth delay line keeping CORDIC side-band data aligned with the cell pipeline.
module cordic_sideband_delay
    import cordic_pkg::*;
#(
    parameter int unsigned CH_W   = CORDIC_CH_W,
    parameter int unsigned NCH    = CORDIC_NCH,
    parameter int unsigned TAG_W  = CORDIC_TAG_W,
    parameter int unsigned DEPTH  = 5,
    parameter int unsigned DSEL_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [NCH*CH_W-1:0]  in_data,
    input  logic [DSEL_W-1:0]    dly_sel,
    output logic                 out_valid,
    output logic [TAG_W-1:0]     out_tag,
    output logic [NCH*CH_W-1:0]  out_data,
    output logic [DSEL_W-1:0]    inflight,
    output logic                 busy,
    output logic                 sel_err
);

    localparam int unsigned DATA_W = NCH * CH_W;

    logic              stg_v    [DEPTH];
    logic [TAG_W-1:0]  stg_tag  [DEPTH];
    logic [DATA_W-1:0] stg_data [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            cordic_dly_stage #(
                .TAG_W  (TAG_W),
                .DATA_W (DATA_W)
            ) u_stage (
                .clk    (clk),
                .reset  (reset),
                .en     (en),
                .flush  (flush),
                .d_v    (in_valid),
                .d_tag  (in_tag),
                .d_data (in_data),
                .q_v    (stg_v[k]),
                .q_tag  (stg_tag[k]),
                .q_data (stg_data[k])
            );
        end else begin : g_body
            cordic_dly_stage #(
                .TAG_W  (TAG_W),
                .DATA_W (DATA_W)
            ) u_stage (
                .clk    (clk),
                .reset  (reset),
                .en     (en),
                .flush  (flush),
                .d_v    (stg_v[k-1]),
                .d_tag  (stg_tag[k-1]),
                .d_data (stg_data[k-1]),
                .q_v    (stg_v[k]),
                .q_tag  (stg_tag[k]),
                .q_data (stg_data[k])
            );
        end
    end

    // Out-of-range or zero select falls back to the full depth.
    logic [DSEL_W-1:0] eff_sel_c;

    always_comb begin
        eff_sel_c = dly_sel;
        if (dly_sel == '0 || dly_sel > DSEL_W'(DEPTH)) begin
            eff_sel_c = DSEL_W'(DEPTH);
        end
    end

    logic              tap_v_c;
    logic [TAG_W-1:0]  tap_tag_c;
    logic [DATA_W-1:0] tap_data_c;
    logic [DSEL_W-1:0] inflight_c;

    // Tap mux and popcount of valid stages up to and including the tap.
    always_comb begin
        tap_v_c    = 1'b0;
        tap_tag_c  = '0;
        tap_data_c = '0;
        inflight_c = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (DSEL_W'(k + 1) == eff_sel_c) begin
                tap_v_c    = stg_v[k];
                tap_tag_c  = stg_tag[k];
                tap_data_c = stg_data[k];
            end
            if (DSEL_W'(k) < eff_sel_c && stg_v[k]) begin
                inflight_c = inflight_c + DSEL_W'(1);
            end
        end
    end

    assign out_valid = tap_v_c;
    assign out_tag   = tap_v_c ? tap_tag_c : '0;
    assign out_data  = tap_v_c ? tap_data_c : '0;
    assign inflight  = inflight_c;
    assign busy      = |inflight_c;

    logic [DSEL_W-1:0] prev_sel_q, prev_sel_d;
    logic              sel_err_q, sel_err_d;

    // Sticky flag: latency select changed while words were still in flight.
    always_comb begin
        prev_sel_d = dly_sel;
        sel_err_d  = sel_err_q;
        if (flush) begin
            sel_err_d = 1'b0;
        end else if (dly_sel != prev_sel_q && busy) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sel_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            prev_sel_q <= prev_sel_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_cordic_sideband_delay.sv
// Directed bench for cordic_sideband_delay with DEPTH=5, NCH=2, CH_W=16, TAG_W=11.
module tb_cordic_sideband_delay;

    localparam int unsigned CH_W   = 16;
    localparam int unsigned NCH    = 2;
    localparam int unsigned TAG_W  = 11;
    localparam int unsigned DEPTH  = 5;
    localparam int unsigned DSEL_W = 3;

    logic                clk;
    logic                reset;
    logic                en;
    logic                flush;
    logic                in_valid;
    logic [TAG_W-1:0]    in_tag;
    logic [NCH*CH_W-1:0] in_data;
    logic [DSEL_W-1:0]   dly_sel;
    logic                out_valid;
    logic [TAG_W-1:0]    out_tag;
    logic [NCH*CH_W-1:0] out_data;
    logic [DSEL_W-1:0]   inflight;
    logic                busy;
    logic                sel_err;

    int n_checks = 0;
    int n_errors = 0;

    cordic_sideband_delay #(
        .CH_W   (CH_W),
        .NCH    (NCH),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH),
        .DSEL_W (DSEL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_tag    (in_tag),
        .in_data   (in_data),
        .dly_sel   (dly_sel),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .out_data  (out_data),
        .inflight  (inflight),
        .busy      (busy),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [TAG_W-1:0] t, input logic [NCH*CH_W-1:0] d);
        in_valid = v;
        in_tag   = t;
        in_data  = d;
    endtask

    initial begin
        int first_hit;

        // 1. reset with every input high
        reset = 1'b0;
        en = 1'b1; flush = 1'b1; in_valid = 1'b1;
        in_tag = '1; in_data = '1; dly_sel = '1;
        repeat (3) tick();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data",  64'(out_data),  64'd0);
        check_eq("rst_out_tag",   64'(out_tag),   64'd0);
        check_eq("rst_inflight",  64'(inflight),  64'd0);
        check_eq("rst_sel_err",   64'(sel_err),   64'd0);
        flush = 1'b0;
        drive(1'b0, '0, '0);
        dly_sel = 3'd5;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) tick();
        check_eq("post_rst_valid",    64'(out_valid), 64'd0);
        check_eq("post_rst_inflight", 64'(inflight),  64'd0);
        check_eq("post_rst_sel_err",  64'(sel_err),   64'd0);

        // 2. basic latency of 5
        drive(1'b1, 11'h2A5, 32'h1234_ABCD);
        tick();
        drive(1'b0, '0, '0);
        check_eq("lat5_inflight", 64'(inflight), 64'd1);
        for (int i = 2; i <= 5; i++) begin
            check_eq("lat5_early_valid", 64'(out_valid), 64'd0);
            tick();
        end
        check_eq("lat5_valid", 64'(out_valid), 64'd1);
        check_eq("lat5_tag",   64'(out_tag),   64'h2A5);
        check_eq("lat5_data",  64'(out_data),  64'h1234_ABCD);
        tick();
        check_eq("lat5_one_cycle", 64'(out_valid), 64'd0);
        check_eq("lat5_data_zero", 64'(out_data),  64'd0);

        // 3. stall with dly_sel=3
        dly_sel = 3'd3;
        repeat (2) tick();
        drive(1'b1, 11'h011, 32'h0000_0011);
        tick();
        drive(1'b0, '0, '0);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("stall_inflight", 64'(inflight),  64'd1);
            check_eq("stall_valid",    64'(out_valid), 64'd0);
        end
        en = 1'b1;
        tick();
        check_eq("stall_valid_early", 64'(out_valid), 64'd0);
        tick();
        check_eq("stall_valid", 64'(out_valid), 64'd1);
        check_eq("stall_tag",   64'(out_tag),   64'h011);
        tick();
        check_eq("stall_gone", 64'(out_valid), 64'd0);

        // 4. streaming with dly_sel=2
        repeat (5) tick();
        dly_sel = 3'd2;
        for (int t = 1; t <= 12; t++) begin
            if (t <= 10) drive(1'b1, TAG_W'(t - 1), {16'(t - 1), 16'hFFFF - 16'(t - 1)});
            else         drive(1'b0, '0, '0);
            tick();
            if (t >= 2 && t <= 11) begin
                check_eq("stream_valid", 64'(out_valid), 64'd1);
                check_eq("stream_tag",   64'(out_tag),   64'(t - 2));
                check_eq("stream_data",  64'(out_data),  64'({16'(t - 2), 16'hFFFF - 16'(t - 2)}));
            end else begin
                check_eq("stream_idle", 64'(out_valid), 64'd0);
            end
            if (t >= 2 && t <= 10) check_eq("stream_inflight", 64'(inflight), 64'd2);
        end

        // 5. flush with en and in_valid
        repeat (5) tick();
        dly_sel = 3'd5;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, TAG_W'(11'h100 + i), 32'hCAFE_0000 + 32'(i));
            tick();
        end
        check_eq("pre_flush_inflight", 64'(inflight), 64'd3);
        check_eq("pre_flush_busy",     64'(busy),     64'd1);
        drive(1'b1, 11'h3FF, 32'hDEAD_BEEF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check_eq("flush_inflight", 64'(inflight),  64'd0);
        check_eq("flush_valid",    64'(out_valid), 64'd0);
        check_eq("flush_busy",     64'(busy),      64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("post_flush_valid", 64'(out_valid), 64'd0);
        end

        // 6. select change while busy, sticky error, flush clear, dly_sel=0
        dly_sel = 3'd4;
        tick();
        drive(1'b1, 11'h055, 32'h5555_0055);
        tick();
        drive(1'b0, '0, '0);
        check_eq("mis_busy",    64'(busy),    64'd1);
        check_eq("mis_err_pre", 64'(sel_err), 64'd0);
        dly_sel = 3'd2;
        tick();
        check_eq("mis_err_set",   64'(sel_err),   64'd1);
        check_eq("mis_new_tap_v", 64'(out_valid), 64'd1);
        check_eq("mis_new_tap_t", 64'(out_tag),   64'h055);
        repeat (3) tick();
        check_eq("mis_err_sticky", 64'(sel_err), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("mis_err_clear", 64'(sel_err), 64'd0);

        dly_sel = 3'd0;
        tick();
        drive(1'b1, 11'h07E, 32'h0707_E0E0);
        tick();
        drive(1'b0, '0, '0);
        first_hit = 0;
        for (int k = 1; k <= 10; k++) begin
            if (out_valid && first_hit == 0) begin
                first_hit = k;
                check_eq("dsel0_tag", 64'(out_tag), 64'h07E);
            end
            if (k < 10) tick();
        end
        check_eq("dsel0_latency", 64'(first_hit), 64'd5);
        check_eq("dsel0_no_err",  64'(sel_err),   64'd0);

        // reset mid-operation drops in-flight words
        drive(1'b1, 11'h123, 32'h0000_0123);
        tick();
        drive(1'b0, '0, '0);
        tick();
        #1 reset = 1'b0;
        #1;
        check_eq("midrst_inflight", 64'(inflight), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        first_hit = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (out_valid) first_hit = 1;
        end
        check_eq("midrst_no_pulse", 64'(first_hit), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
